// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Wide enough to count every SCLK edge of one frame.
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: emits a one-cycle tick on the last cycle of every
// load_val-cycle period, restarting the period on a synchronous clear.
module spi_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // A count of 0 only occurs after reset; treat it as expired.
    assign tick = (cnt <= DIV_W'(1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= load_val;
        else
            cnt <= cnt - DIV_W'(1);
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-frame mode-0 SPI master: chip select, SCLK generation and
// MSB-first shifting for one command per start handshake.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  div_half,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int EW = edge_cnt_w(DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    spi_state_e        state, state_nx;
    logic [DIV_W-1:0]  h_reg, h_nx, h_in, load_val;
    logic [EW-1:0]     edge_cnt, edge_nx;
    logic [DATA_W-1:0] tx_sr, tx_sr_nx;
    logic [DATA_W-1:0] rx_sr, rx_sr_nx;
    logic [DATA_W-1:0] rx_data_nx;
    logic              busy_nx, done_nx, sclk_nx, mosi_nx, cs_n_nx;
    logic              tick, clear;

    assign h_in     = (div_half == '0) ? DIV_W'(1) : div_half;
    // In IDLE the timer preloads from the live input so SETUP starts with
    // the freshly accepted half-period.
    assign load_val = (state == IDLE) ? h_in : h_reg;
    assign clear    = (state_nx != state) || (state == IDLE);

    spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear    (clear),
        .load_val (load_val),
        .tick     (tick)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        h_nx       = h_reg;
        edge_nx    = edge_cnt;
        tx_sr_nx   = tx_sr;
        rx_sr_nx   = rx_sr;
        rx_data_nx = rx_data;
        busy_nx    = busy;
        done_nx    = 1'b0;
        sclk_nx    = sclk;
        mosi_nx    = mosi;
        cs_n_nx    = cs_n;
        case (state)
            IDLE: begin
                sclk_nx = CPOL;
                cs_n_nx = 1'b1;
                if (start) begin
                    state_nx = SETUP;
                    h_nx     = h_in;
                    tx_sr_nx = tx_data;
                    rx_sr_nx = '0;
                    edge_nx  = '0;
                    busy_nx  = 1'b1;
                    cs_n_nx  = 1'b0;
                    mosi_nx  = tx_data[DATA_W-1];
                end
            end
            SETUP: begin
                if (tick) begin
                    state_nx = XFER;
                    sclk_nx  = ~CPOL;
                    rx_sr_nx = {rx_sr[DATA_W-2:0], miso};
                    edge_nx  = EW'(1);
                end
            end
            XFER: begin
                if (tick) begin
                    edge_nx = edge_cnt + EW'(1);
                    if (sclk) begin
                        sclk_nx = 1'b0;
                        // Last falling edge has no next bit; mosi keeps the LSB.
                        if (edge_cnt + EW'(1) == LAST_EDGE) begin
                            state_nx = HOLD;
                        end else begin
                            tx_sr_nx = {tx_sr[DATA_W-2:0], 1'b0};
                            mosi_nx  = tx_sr[DATA_W-2];
                        end
                    end else begin
                        sclk_nx  = 1'b1;
                        rx_sr_nx = {rx_sr[DATA_W-2:0], miso};
                    end
                end
            end
            HOLD: begin
                sclk_nx = CPOL;
                if (tick) begin
                    state_nx   = IDLE;
                    cs_n_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    done_nx    = 1'b1;
                    rx_data_nx = rx_sr;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            h_reg    <= DIV_W'(1);
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= CPOL;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            h_reg    <= h_nx;
            edge_cnt <= edge_nx;
            tx_sr    <= tx_sr_nx;
            rx_sr    <= rx_sr_nx;
            rx_data  <= rx_data_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            sclk     <= sclk_nx;
            mosi     <= mosi_nx;
            cs_n     <= cs_n_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus queues expected frames,
// a negedge monitor measures each frame on the pins and compares at done.
module tb_spi_master_ctrl;

    localparam int DW = 8;
    localparam int VW = 8;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [VW-1:0] div_half = '0;
    logic          busy, done, sclk, mosi, cs_n, miso;
    logic [DW-1:0] rx_data;

    logic          loopback   = 1'b1;
    logic [DW-1:0] slave_word = '0;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] tx;
        int            h;
    } exp_t;

    exp_t q[$];
    int vecs = 0;
    int errs = 0;

    int            blen  = 0;
    int            rises = 0;
    logic [DW-1:0] mword = '0;
    logic          psclk = 1'b0;
    logic          pbusy = 1'b0;

    spi_master_ctrl #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .start    (start),
        .tx_data  (tx_data),
        .div_half (div_half),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
    );

    always #5 clk_in = ~clk_in;

    // Peripheral model: echo mosi, or shift out slave_word MSB first, one
    // bit per SCLK rise already seen.
    always_comb begin
        if (loopback)
            miso = mosi;
        else if (rises < DW)
            miso = slave_word[DW-1-rises];
        else
            miso = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_n) begin
            blen  = 0;
            rises = 0;
            mword = '0;
            psclk = 1'b0;
            pbusy = 1'b0;
        end else begin
            if (busy && !pbusy)
                check("frame_expected", 32'(q.size() > 0), 32'd1);
            if (busy) blen++;
            if (sclk && !psclk) begin
                rises++;
                mword = {mword[DW-2:0], mosi};
                if (rises == 1 && q.size() > 0)
                    check("first_rise_cycle", 32'(blen), 32'(q[0].h + 1));
            end
            if (done) begin
                if (q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("busy_len", 32'(blen), 32'((2 * DW + 1) * e.h));
                    check("sclk_rises", 32'(rises), 32'(DW));
                    check("mosi_word", 32'(mword), 32'(e.tx));
                    check("cs_n_at_done", 32'(cs_n), 32'd1);
                    check("busy_at_done", 32'(busy), 32'd0);
                end
                blen  = 0;
                rises = 0;
                mword = '0;
            end
            psclk = sclk;
            pbusy = busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        if (q.size() != 0 || busy) begin
            vecs++;
            errs++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, q.size());
        end
    endtask

    task automatic frame(input logic [DW-1:0] tx, input logic [VW-1:0] div,
                         input logic lb, input logic [DW-1:0] sw, input logic hold);
        exp_t e;
        wait_idle();
        @(negedge clk_in);
        tx_data    = tx;
        div_half   = div;
        loopback   = lb;
        slave_word = sw;
        start      = 1'b1;
        @(posedge clk_in);
        e.tx = tx;
        e.rx = lb ? tx : sw;
        e.h  = (div == 0) ? 1 : int'(div);
        q.push_back(e);
        #1;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int n;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        @(negedge clk_in);
        rst_n = 1'b1;

        frame(8'hA5, 8'd2, 1'b1, 8'h00, 1'b0);
        frame(8'h00, 8'd3, 1'b0, 8'hFF, 1'b0);
        frame(8'h6E, 8'd0, 1'b1, 8'h00, 1'b0);
        frame(8'h81, 8'd0, 1'b0, 8'h3B, 1'b0);

        // Mid-frame start pulse and config change must be ignored.
        frame(8'h3C, 8'd2, 1'b1, 8'h00, 1'b0);
        repeat (10) @(negedge clk_in);
        start    = 1'b1;
        tx_data  = 8'hFF;
        div_half = 8'd5;
        @(negedge clk_in);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk_in);
        check("no_second_frame", 32'(busy), 32'd0);

        // Back-to-back: start held across done.
        frame(8'h5A, 8'd1, 1'b1, 8'h00, 1'b1);
        @(negedge clk_in);
        tx_data  = 8'hC3;
        div_half = 8'd2;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        check("b2b_done_seen", 32'(done), 32'd1);
        check("b2b_cs_n_gap", 32'(cs_n), 32'd1);
        @(posedge clk_in);
        e.tx = 8'hC3;
        e.rx = 8'hC3;
        e.h  = 2;
        q.push_back(e);
        #1;
        start = 1'b0;
        @(negedge clk_in);
        check("b2b_cs_n_low_again", 32'(cs_n), 32'd0);
        check("b2b_busy_again", 32'(busy), 32'd1);
        wait_idle();

        // Reset in cycle 10 of a frame aborts it with no done.
        frame(8'h96, 8'd2, 1'b1, 8'h00, 1'b0);
        repeat (9) @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_in);
        check("abort_stays_idle", 32'(busy), 32'd0);
        check("abort_rx_kept", 32'(rx_data), 32'd0);

        for (int i = 0; i < 25; i++) begin
            frame(DW'($urandom), VW'($urandom_range(0, 4)), 1'($urandom),
                  DW'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
        end
        wait_idle();
        repeat (5) @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-frame SPI master (mode 0, MSB first) that sequences chip select, serial clock generation and shifting for one peripheral. It sits between a simple start/done command interface and the SPI pins. Its SCLK half-period is set at run time through `div_half`, which replaces a fixed divider. Each accepted command produces exactly one framed transfer of `DATA_W` bits and returns the received word.

## Interface
Parameters:
- `DATA_W`, default 8: bits per frame; must be ≥ 2.
- `DIV_W`, default 8: width of the `div_half` input.

Ports:
- `clk_in`, input, 1: system clock. Rising-edge only.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: command request. Sampled only in IDLE.
- `tx_data`, input, `DATA_W`: word to transmit. Latched when a command is accepted.
- `div_half`, input, `DIV_W`: SCLK half-period in `clk_in` cycles. Latched when a command is accepted; a value of 0 is treated as 1.
- `busy`, output, 1: a frame is in progress.
- `done`, output, 1: one-cycle pulse at frame end.
- `rx_data`, output, `DATA_W`: last received word. Held until the next `done`.
- `sclk`, output, 1: SPI clock. Idles low.
- `mosi`, output, 1: serial data out.
- `miso`, input, 1: serial data in. Treated as synchronous to `clk_in`; no synchronizer is required.
- `cs_n`, output, 1: active-low chip select.

## Operation
Reset values: `busy=0`, `done=0`, `rx_data=0`, `sclk=0`, `mosi=0`, `cs_n=1`. Internal state returns to IDLE with the counter and shift registers cleared.

Let H = max(`div_half`, 1), latched at accept. A "tick" is the last cycle of each H-cycle period. The period counter clears on every state entry.

State machine:
- **IDLE**
  - `cs_n=1`, `sclk=0`.
  - When `start=1`: latch `tx_data` and H, then go to SETUP. This edge is the accept edge.
- **SETUP** (H cycles)
  - `cs_n=0`, `mosi`=`tx_data[DATA_W-1]`.
  - On tick: `sclk` rises (edge 1), `miso` is shifted into the rx register, go to XFER.
- **XFER**
  - Each tick toggles `sclk`.
  - On a falling edge: `mosi` shifts to the next bit.
  - On a rising edge: `miso` shifts into the LSB of the rx register.
  - After edge 2·`DATA_W` (a falling edge), go to HOLD with `sclk=0`.
  - There are exactly `DATA_W` rising and `DATA_W` falling edges per frame.
- **HOLD** (H cycles)
  - `cs_n=0`, `sclk=0`.
  - On tick: go to IDLE, and in the same register update set `cs_n=1`, `rx_data`=rx shift register, `done=1` for one cycle.

Handshake and boundary rules:
- `start` while `busy=1` is ignored (not queued).
- `start=1` in the cycle where `done=1` is accepted, giving back-to-back frames with `cs_n` high for exactly 1 cycle.
- Changes to `tx_data` or `div_half` after accept have no effect on the current frame.
- `mosi` holds its last driven bit after the frame; its value is don't-care while `cs_n=1`.
- An asynchronous reset during a frame aborts it immediately. Outputs take their reset values with no `done` and no partial `rx_data` update.

## Timing
- Accept at edge T. `busy=1` and `cs_n=0` are visible from cycle T+1.
- First SCLK rise occurs at T+1+H.
- Frame length, with `busy=1`: (2·`DATA_W`+1)·H cycles. Example: `DATA_W`=8, H=2 gives 34 cycles.
- `done=1`, `busy=0` and `cs_n=1` all appear in the same cycle, immediately after the last `busy` cycle.
- `mosi` is stable for at least H cycles before and after each rising `sclk` edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `spi_pkg`:
  - state enum: IDLE, SETUP, XFER, HOLD.
  - SPI mode constants: CPOL=0, CPHA=0.
  - edge-count width function: clog2(2·`DATA_W`+1).
- Sub-module `spi_tick_gen`:
  - `DIV_W` down-counter with load value H and a synchronous clear.
  - Outputs a 1-cycle `tick`.
  - Instantiated once.
- The top level holds the FSM, the edge counter, and the tx/rx shift registers.

## Test plan
- **Loopback:** `mosi`→`miso`, `tx_data`=0xA5, `div_half`=2. Expect `rx_data`=0xA5, `busy` high 34 cycles, 8 SCLK rises, `done` a single pulse.
- **Constant input:** `miso`=1, `tx_data`=0x00, `div_half`=3. Expect `rx_data`=0xFF, `mosi`=0 throughout, `cs_n` low 51 cycles.
- **Zero divider:** `div_half`=0. Expect behaviour identical to `div_half`=1 (17-cycle frame, SCLK toggles every cycle).
- **Start and config handling:**
  - Pulse `start` mid-frame and change `div_half`/`tx_data` mid-frame: no effect on the current frame, and no second frame follows.
  - Hold `start` high across `done`: a second frame starts with `cs_n` high exactly 1 cycle.
- **Mid-frame reset:** assert `rst_n` low at cycle 10 of a frame. Expect `cs_n=1`, `sclk=0`, `busy=0` immediately, `rx_data` unchanged at 0, and no `done`.
